// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  // req_len encodes bytes-1
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd3;

  localparam logic [1:0] IO_SEL    = 2'b11;
  localparam int         IO_SEL_HI = 17;
  localparam int         IO_SEL_LO = 16;

  // The illegal encoding 2 is promoted to a 4-byte access
  function automatic logic [1:0] eff_len(input logic [1:0] len);
    case (len)
      LEN_1B:  return LEN_1B;
      LEN_2B:  return LEN_2B;
      default: return LEN_4B;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM/IO bus bundle; master = CPU side, slave = controller.
interface mem_ctrl_if #(
  parameter int NPORTS = 2,
  parameter int ADDR_W = 32
);
  logic [NPORTS-1:0]             req_valid;
  logic [NPORTS-1:0]             req_wr;
  logic [NPORTS-1:0][1:0]        req_len;
  logic [NPORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NPORTS-1:0][31:0]       req_wdata;
  logic [NPORTS-1:0]             resp_valid;
  logic [31:0]                   resp_rdata;
  logic                          busy;
  logic [7:0]                    mem_din;
  logic [7:0]                    mem_dout;
  logic [31:0]                   mem_a;
  logic                          mem_wr;
  logic                          io_buffer_full;

  modport master (
    output req_valid, req_wr, req_len, req_addr, req_wdata, mem_din, io_buffer_full,
    input  resp_valid, resp_rdata, busy, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  req_valid, req_wr, req_len, req_addr, req_wdata, mem_din, io_buffer_full,
    output resp_valid, resp_rdata, busy, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Combinational requester arbiter: fixed lowest-index or round-robin after last_grant.
module rr_arbiter #(
  parameter int NPORTS  = 2,
  parameter int RR_MODE = 0,
  parameter int IDX_W   = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [NPORTS-1:0] mask,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NPORTS-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);
  logic [NPORTS-1:0] elig;
  assign elig = req & ~mask;

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < NPORTS; i++) begin
        j = (int'(last_grant) + 1 + i) % NPORTS;
        if (!gnt_vld && elig[j]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(j);
        end
      end
    end else begin
      // descending scan so the lowest index is the last writer
      for (int i = NPORTS - 1; i >= 0; i--) begin
        if (elig[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
    gnt[gnt_idx] = gnt_vld;
  end
endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates requesters and splits 1/2/4B accesses into LE bytes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NPORTS  = 2,
  parameter int RR_MODE = 0,
  parameter int ADDR_W  = 32
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  mem_ctrl_if.slave  bus
);
  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          len_q, len_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NPORTS-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic                issued_q, issued_d;
  logic [1:0]          idx_q, idx_d;

  logic [NPORTS-1:0]   arb_mask, arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_vld;
  logic [ADDR_W-1:0]   cur_addr;
  logic                io_stall;
  logic                wr_en;

  rr_arbiter #(.NPORTS(NPORTS), .RR_MODE(RR_MODE), .IDX_W(IDX_W)) u_arb (
    .req        (bus.req_valid),
    .mask       (arb_mask),
    .last_grant (last_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .gnt_vld    (arb_vld)
  );

  assign arb_mask = (state_q == DONE) ? gnt_q : '0;
  assign cur_addr = addr_q + ADDR_W'(cnt_q);
  assign io_stall = (cur_addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL) && bus.io_buffer_full;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    idx_d    = idx_q;
    issued_d = 1'b0;
    wr_en    = 1'b0;
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    bus.mem_a      = '0;
    bus.mem_dout   = '0;
    bus.mem_wr     = 1'b0;
    bus.busy       = (state_q != IDLE);

    // a byte issued last active cycle lands regardless of rdy_in: it is already on the bus
    if (issued_q) rdata_d[{idx_q, 3'b000} +: 8] = bus.mem_din;

    case (state_q)
      IDLE: begin
        if (rdy_in && arb_vld) begin
          gnt_d   = arb_gnt;
          last_d  = arb_idx;
          addr_d  = bus.req_addr[arb_idx];
          len_d   = eff_len(bus.req_len[arb_idx]);
          wdata_d = bus.req_wdata[arb_idx];
          rdata_d = '0;
          cnt_d   = '0;
          state_d = bus.req_wr[arb_idx] ? WRITE : READ;
        end
      end
      READ: begin
        if (cnt_q <= {1'b0, len_q}) begin
          bus.mem_a = 32'(cur_addr);
          if (rdy_in) begin
            issued_d = 1'b1;
            idx_d    = cnt_q[1:0];
            cnt_d    = cnt_q + 3'd1;
          end
        end else if (rdy_in) begin
          state_d = DONE;
        end
      end
      WRITE: begin
        bus.mem_a    = 32'(cur_addr);
        bus.mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        wr_en        = rdy_in && !io_stall;
        bus.mem_wr   = wr_en;
        if (wr_en) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q[1:0] == len_q) state_d = DONE;
        end
      end
      DONE: begin
        bus.resp_rdata = rdata_q;
        if (rdy_in) begin
          bus.resp_valid = gnt_q;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      last_q   <= IDX_W'(NPORTS - 1);
      issued_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      issued_q <= issued_d;
      idx_q    <= idx_d;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fixed-priority and round-robin instances share one stimulus.
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.NPORTS(2), .ADDR_W(32)) bf ();
  mem_ctrl_if #(.NPORTS(2), .ADDR_W(32)) br ();

  mem_ctrl #(.NPORTS(2), .RR_MODE(0), .ADDR_W(32)) dut_fx (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(bf.slave));
  mem_ctrl #(.NPORTS(2), .RR_MODE(1), .ADDR_W(32)) dut_rr (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .bus(br.slave));

  assign br.req_valid      = bf.req_valid;
  assign br.req_wr         = bf.req_wr;
  assign br.req_len        = bf.req_len;
  assign br.req_addr       = bf.req_addr;
  assign br.req_wdata      = bf.req_wdata;
  assign br.io_buffer_full = bf.io_buffer_full;
  assign br.mem_din        = 8'h00;

  int n_cmp, n_err;
  logic [31:0] la [0:31];
  logic        lw [0:31];
  logic [7:0]  ld [0:31];
  logic        lb [0:31];
  logic [39:0] wlog [$];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 8'h11;
      32'h0000_0101: return 8'h22;
      32'h0000_0102: return 8'h33;
      32'h0000_0103: return 8'h44;
      32'hFFFF_FFFF: return 8'h5A;
      32'h0000_0000: return 8'hA5;
      default:       return 8'h00;
    endcase
  endfunction

  // RAM returns the byte the cycle after its address; writes are logged
  always @(posedge clk) begin
    bf.mem_din <= rd_byte(bf.mem_a);
    if (bf.mem_wr) wlog.push_back({bf.mem_a, bf.mem_dout});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nwr(input logic [31:0] a, input int from);
    int n = 0;
    for (int i = from; i < wlog.size(); i++)
      if (wlog[i][39:8] == a) n++;
    return n;
  endfunction

  // Request raised in cycle 0; iom/rdym bit c sets io_buffer_full / rdy_in low in cycle c
  task automatic do_req(input int port, input logic wr, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] iom, input logic [31:0] rdym, input int maxc,
                        output int rc, output logic [31:0] rd);
    rc = -1;
    rd = '0;
    @(negedge clk);
    bf.req_valid[port] = 1'b1;
    bf.req_wr[port]    = wr;
    bf.req_len[port]   = len;
    bf.req_addr[port]  = addr;
    bf.req_wdata[port] = wdata;
    rdy = !rdym[0];
    bf.io_buffer_full = iom[0];
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk);
      #1;
      rdy = !rdym[c];
      bf.io_buffer_full = iom[c];
      @(negedge clk);
      la[c] = bf.mem_a;
      lw[c] = bf.mem_wr;
      ld[c] = bf.mem_dout;
      lb[c] = bf.busy;
      if (bf.resp_valid[port] && rc < 0) begin
        rc = c;
        rd = bf.resp_rdata;
        bf.req_valid[port] = 1'b0;
      end
    end
    rdy = 1'b1;
    bf.io_buffer_full = 1'b0;
  endtask

  initial begin
    int rc, w0;
    logic [31:0] rd, r0;
    logic seen;
    int gfx [$];
    int grr [$];
    int cfx [$];
    n_cmp = 0;
    n_err = 0;
    bf.req_valid = '0;
    bf.req_wr    = '0;
    bf.req_len   = '0;
    bf.req_addr  = '0;
    bf.req_wdata = '0;
    bf.io_buffer_full = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'd0, bf.busy}, 32'd0);
    chk("rst_mem_a", bf.mem_a, 32'd0);
    chk("rst_wr",    {31'd0, bf.mem_wr}, 32'd0);
    chk("rst_dout",  {24'd0, bf.mem_dout}, 32'd0);
    chk("rst_resp",  {30'd0, bf.resp_valid}, 32'd0);
    chk("rst_rdata", bf.resp_rdata, 32'd0);
    rst_n = 1'b1;

    // 4B read at 0x100
    do_req(0, 1'b0, 2'd3, 32'h100, 32'h0, 32'h0, 32'h0, 8, rc, rd);
    for (int c = 1; c <= 4; c++) chk($sformatf("rd4_a%0d", c), la[c], 32'h100 + c - 1);
    chk("rd4_wr",     {31'd0, lw[2]}, 32'd0);
    chk("rd4_cyc",    rc, 32'd6);
    chk("rd4_rdata",  rd, 32'h4433_2211);
    chk("rd4_busy1",  {31'd0, lb[1]}, 32'd1);
    chk("rd4_busy6",  {31'd0, lb[6]}, 32'd1);
    chk("rd4_busy7",  {31'd0, lb[7]}, 32'd0);
    chk("rd4_idle_a", la[7], 32'd0);

    // 1B IO write with UART full for 3 cycles
    w0 = wlog.size();
    do_req(1, 1'b1, 2'd0, 32'h3_0000, 32'h41, 32'b1110, 32'h0, 8, rc, rd);
    chk("io_stall",  {29'd0, lw[1], lw[2], lw[3]}, 32'd0);
    chk("io_wr",     {31'd0, lw[4]}, 32'd1);
    chk("io_a",      la[4], 32'h3_0000);
    chk("io_dout",   {24'd0, ld[4]}, 32'h41);
    chk("io_cyc",    rc, 32'd5);
    chk("io_nwr",    wlog.size() - w0, 32'd1);

    // 4B write with rdy low in cycles 2-3
    w0 = wlog.size();
    do_req(0, 1'b1, 2'd3, 32'h200, 32'hDDCC_BBAA, 32'h0, 32'b1100, 10, rc, rd);
    chk("wr4_b0",     {lw[1], 7'd0, ld[1], la[1][15:0]}, {1'b1, 7'd0, 8'hAA, 16'h0200});
    chk("wr4_frozen", {30'd0, lw[2], lw[3]}, 32'd0);
    chk("wr4_b1",     {lw[4], 7'd0, ld[4], la[4][15:0]}, {1'b1, 7'd0, 8'hBB, 16'h0201});
    chk("wr4_b3",     {24'd0, ld[6]}, 32'hDD);
    chk("wr4_cyc",    rc, 32'd7);
    chk("wr4_total",  wlog.size() - w0, 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("wr4_once%0d", k), nwr(32'h200 + k, w0), 32'd1);

    // 4B read with rdy low in cycle 3: byte 1 already on the bus is still captured
    do_req(0, 1'b0, 2'd3, 32'h100, 32'h0, 32'h0, 32'b1000, 10, rc, rd);
    chk("rdp_cyc",   rc, 32'd7);
    chk("rdp_rdata", rd, 32'h4433_2211);
    chk("rdp_a4",    la[4], 32'h102);

    // reset in the middle of a 4B read
    @(negedge clk);
    bf.req_valid[0] = 1'b1;
    bf.req_wr[0]    = 1'b0;
    bf.req_len[0]   = 2'd3;
    bf.req_addr[0]  = 32'h100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", {31'd0, bf.busy}, 32'd1);
    chk("mid_a",    bf.mem_a, 32'h101);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bf.busy}, 32'd0);
    chk("arst_a",    bf.mem_a, 32'd0);
    bf.req_valid[0] = 1'b0;
    seen = 1'b0;
    repeat (3) @(negedge clk) seen |= |bf.resp_valid;
    rst_n = 1'b1;
    repeat (4) @(negedge clk) seen |= |bf.resp_valid;
    chk("arst_noresp", {31'd0, seen}, 32'd0);

    // 2B read wrapping past the top of the address space
    do_req(0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 6, rc, rd);
    chk("wrap_a1",    la[1], 32'hFFFF_FFFF);
    chk("wrap_a2",    la[2], 32'h0);
    chk("wrap_cyc",   rc, 32'd4);
    chk("wrap_rdata", rd, 32'h0000_A55A);

    // both ports requesting continuously; fresh reset so RR starts at port 0
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    bf.req_wr    = '0;
    bf.req_len   = '0;
    bf.req_addr[0] = 32'h100;
    bf.req_addr[1] = 32'h101;
    bf.req_valid = 2'b11;
    r0 = '0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (|bf.resp_valid) begin
        if (gfx.size() == 0) r0 = bf.resp_rdata;
        gfx.push_back(bf.resp_valid[1] ? 1 : 0);
        cfx.push_back(c);
      end
      if (|br.resp_valid) grr.push_back(br.resp_valid[1] ? 1 : 0);
      if (c == 15) bf.req_valid[0] = 1'b0;
    end
    bf.req_valid = '0;
    chk("fx_count", gfx.size(), 32'd5);
    chk("fx_seq",   {gfx[0][7:0], gfx[1][7:0], gfx[2][7:0], gfx[3][7:0]}, 32'h0000_0000);
    chk("fx_p1",    gfx[4], 32'd1);
    chk("fx_cyc0",  cfx[0], 32'd3);
    chk("fx_cyc4",  cfx[4], 32'd19);
    chk("fx_rdata", r0, 32'h11);
    chk("rr_count", grr.size(), 32'd5);
    chk("rr_seq",   {grr[0][7:0], grr[1][7:0], grr[2][7:0], grr[3][7:0]}, 32'h0001_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
